uart_tx_core: RTL and testbench



---
 rtl/uart_tx_core.sv | 122 ++++++++++++
 tb/tb_uart_tx_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: 1 start bit, NBITS data bits LSB first, 1 stop bit,
// each bit lasting OS_TICKS oversampling ticks; pops bytes from a FWFT FIFO.
module uart_tx_core #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned OS_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_tick,
    input  logic             tx_fifo_empty,
    input  logic [NBITS-1:0] tx_din,
    output logic             tx_fifo_rd,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int unsigned OS_W  = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;
    localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [OS_W-1:0]    os_count_q, os_count_d;
    logic [BIT_W-1:0]   bit_count_q, bit_count_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               tx_done_q, tx_done_d;
    logic               bit_end;

    // A bit ends on the tick that sees the last oversampling slot
    assign bit_end = tx_tick && (os_count_q == OS_W'(OS_TICKS - 1));

    always_comb begin
        state_d     = state_q;
        os_count_d  = os_count_q;
        bit_count_d = bit_count_q;
        shreg_d     = shreg_q;
        tx_done_d   = 1'b0;
        tx_fifo_rd  = 1'b0;
        tx_d        = 1'b1;

        unique case (state_q)
            IDLE: begin
                // Ticks in the pop cycle are deliberately not counted
                if (!tx_fifo_empty) begin
                    tx_fifo_rd = rst_n;
                    shreg_d    = tx_din;
                    os_count_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    os_count_d  = '0;
                    bit_count_d = '0;
                    state_d     = DATA;
                end else if (tx_tick) begin
                    os_count_d = os_count_q + OS_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d    = shreg_q >> 1;
                    os_count_d = '0;
                    if (bit_count_q == BIT_W'(NBITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_count_d = bit_count_q + BIT_W'(1);
                    end
                end else if (tx_tick) begin
                    os_count_d = os_count_q + OS_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    os_count_d = '0;
                    tx_done_d  = 1'b1;
                    state_d    = IDLE;
                end else if (tx_tick) begin
                    os_count_d = os_count_q + OS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so it switches with the state
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            os_count_q  <= '0;
            bit_count_q <= '0;
            shreg_q     <= '0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_count_q  <= os_count_d;
            bit_count_q <= bit_count_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = tx_done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core: reset, single frame,
// back-to-back frames, slow tick, mid-frame reset and long idle.
module tb_uart_tx_core;

    logic       clk;
    logic       rst_n;
    logic       tx_tick;
    logic       tx_fifo_empty;
    logic [7:0] tx_din;
    logic       tx_fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_core #(.NBITS(8), .OS_TICKS(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_tick       (tx_tick),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_din        (tx_din),
        .tx_fifo_rd    (tx_fifo_rd),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, then let outputs settle
    task automatic cycle(input logic r, input logic e, input logic t, input logic [7:0] d);
        @(negedge clk);
        rst_n         = r;
        tx_fifo_empty = e;
        tx_tick       = t;
        tx_din        = d;
        #1;
    endtask

    // Frame bit idx: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'hA5);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx cyc%0d got %b exp 1", i, tx); end
            checks++; if (tx_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd cyc%0d got %b exp 0", i, tx_fifo_rd); end
            checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, tx_busy); end
            checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done cyc%0d got %b exp 0", i, tx_done); end
        end
        cycle(1'b1, 1'b1, 1'b1, 8'h00);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy);
        end
    endtask

    task automatic test_single_a5();
        logic exp_tx;
        int   rd_cnt;
        cycle(1'b1, 1'b0, 1'b1, 8'hA5);
        rd_cnt = (tx_fifo_rd === 1'b1) ? 1 : 0;
        checks++; if (tx_fifo_rd !== 1'b1) begin errors++; $display("FAIL a5_pop got %b exp 1", tx_fifo_rd); end
        for (int k = 1; k <= 161; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'h00);
            if (tx_fifo_rd === 1'b1) rd_cnt++;
            exp_tx = (k <= 160) ? frame_bit(8'hA5, (k - 1) / 16) : 1'b1;
            checks++; if (tx !== exp_tx) begin errors++; $display("FAIL a5_tx k=%0d got %b exp %b", k, tx, exp_tx); end
            checks++; if (tx_busy !== (k <= 160)) begin errors++; $display("FAIL a5_busy k=%0d got %b exp %b", k, tx_busy, k <= 160); end
            checks++; if (tx_done !== (k == 161)) begin errors++; $display("FAIL a5_done k=%0d got %b exp %b", k, tx_done, k == 161); end
        end
        checks++; if (rd_cnt != 1) begin errors++; $display("FAIL a5_rd_count got %0d exp 1", rd_cnt); end
    endtask

    task automatic test_back_to_back();
        logic exp_tx;
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        checks++; if (tx_fifo_rd !== 1'b1) begin errors++; $display("FAIL b2b_pop1 got %b exp 1", tx_fifo_rd); end
        // FIFO stays non-empty; head is now 0xFF
        for (int k = 1; k <= 160; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'hFF);
            exp_tx = frame_bit(8'h00, (k - 1) / 16);
            checks++; if (tx_fifo_rd !== 1'b0) begin errors++; $display("FAIL b2b_rd_midframe k=%0d got %b exp 0", k, tx_fifo_rd); end
            checks++; if (tx !== exp_tx) begin errors++; $display("FAIL b2b_tx0 k=%0d got %b exp %b", k, tx, exp_tx); end
            checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy0 k=%0d got %b exp 1", k, tx_busy); end
        end
        cycle(1'b1, 1'b0, 1'b1, 8'hFF);
        checks++; if (tx_fifo_rd !== 1'b1) begin errors++; $display("FAIL b2b_pop2_at_161 got %b exp 1", tx_fifo_rd); end
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", tx_done); end
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap tx=%b busy=%b exp 1 0", tx, tx_busy); end
        for (int k = 162; k <= 322; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'h00);
            exp_tx = (k <= 321) ? frame_bit(8'hFF, (k - 162) / 16) : 1'b1;
            checks++; if (tx !== exp_tx) begin errors++; $display("FAIL b2b_tx1 k=%0d got %b exp %b", k, tx, exp_tx); end
            checks++; if (tx_done !== (k == 322)) begin errors++; $display("FAIL b2b_done2 k=%0d got %b exp %b", k, tx_done, k == 322); end
        end
    endtask

    task automatic test_tick4_3c();
        logic exp_tx;
        logic tk;
        int   rd_cnt;
        int   start_len;
        // Pop coincides with a tick that must not be counted
        cycle(1'b1, 1'b0, 1'b1, 8'h3C);
        rd_cnt = (tx_fifo_rd === 1'b1) ? 1 : 0;
        start_len = 0;
        for (int k = 1; k <= 641; k++) begin
            tk = ((k % 4) == 0);
            cycle(1'b1, (k < 8) ? 1'b1 : 1'b0, tk, 8'h3C);
            if (tx_fifo_rd === 1'b1) rd_cnt++;
            if (k <= 640) begin
                exp_tx = frame_bit(8'h3C, (k - 1) / 64);
                checks++; if (tx !== exp_tx) begin errors++; $display("FAIL t4_tx k=%0d got %b exp %b", k, tx, exp_tx); end
                checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL t4_busy k=%0d got %b exp 1", k, tx_busy); end
                if (k <= 64 && tx === 1'b0) start_len++;
            end else begin
                checks++; if (tx_done !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL t4_end done=%b tx=%b exp 1 1", tx_done, tx); end
            end
            if (k > 8 && k <= 640 && tx_fifo_rd !== 1'b0) begin
                checks++; errors++; $display("FAIL t4_rd_midframe k=%0d got %b exp 0", k, tx_fifo_rd);
            end
        end
        checks++; if (start_len < 64 || start_len > 67) begin errors++; $display("FAIL t4_start_len got %0d exp 64..67", start_len); end
        // The last cycle above was IDLE with a non-empty FIFO: that was a second pop
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL t4_rd_count got %0d exp 2 (frame pop + next pop)", rd_cnt); end
        // Abandon the second frame with reset
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL t4_cleanup tx=%b busy=%b exp 1 0", tx, tx_busy); end
    endtask

    task automatic test_reset_mid_data();
        logic exp_tx;
        cycle(1'b1, 1'b0, 1'b1, 8'h0F);
        checks++; if (tx_fifo_rd !== 1'b1) begin errors++; $display("FAIL rm_pop got %b exp 1", tx_fifo_rd); end
        for (int k = 1; k <= 85; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'h00);
            exp_tx = frame_bit(8'h0F, (k - 1) / 16);
            checks++; if (tx !== exp_tx) begin errors++; $display("FAIL rm_tx k=%0d got %b exp %b", k, tx, exp_tx); end
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        checks++; if (tx_fifo_rd !== 1'b0) begin errors++; $display("FAIL rm_rd_in_reset got %b exp 0", tx_fifo_rd); end
        for (int k = 0; k < 200; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'h00);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rm_tx_after k=%0d got %b exp 1", k, tx); end
            checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after k=%0d got %b exp 0", k, tx_busy); end
            checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rm_done_after k=%0d got %b exp 0", k, tx_done); end
        end
    endtask

    task automatic test_empty_idle();
        for (int k = 0; k < 1000; k++) begin
            cycle(1'b1, 1'b1, ((k % 2) == 0), 8'h5A);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx k=%0d got %b exp 1", k, tx); end
            checks++; if (tx_fifo_rd !== 1'b0) begin errors++; $display("FAIL idle_rd k=%0d got %b exp 0", k, tx_fifo_rd); end
            checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy k=%0d got %b exp 0", k, tx_busy); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        tx_tick       = 1'b0;
        tx_fifo_empty = 1'b0;
        tx_din        = 8'h00;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_tick4_3c();
        test_reset_mid_data();
        test_empty_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
